// File: rtl/wb_commit_buffer.sv
// MEM->WB commit register with a two-entry skid buffer, valid/ready handshaking,
// duplicate-PC suppression, x0 write masking and a retire counter.
module wb_commit_buffer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned LANES  = 1,
  parameter int unsigned DEDUP  = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         in_pc,
  input  logic [LANES*REG_AW-1:0] in_rd,
  input  logic [LANES*XLEN-1:0]   in_wdata,
  input  logic [LANES-1:0]        in_wreg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_W-1:0]         out_pc,
  output logic [LANES*REG_AW-1:0] out_rd,
  output logic [LANES*XLEN-1:0]   out_wdata,
  output logic [LANES-1:0]        out_wreg,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam bit DedupEn = (DEDUP != 0);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                  r_state;
  logic [PC_W-1:0]         r_last_pc;
  logic                    r_last_pc_valid;
  logic [PC_W-1:0]         r_skid_pc;
  logic [LANES*REG_AW-1:0] r_skid_rd;
  logic [LANES*XLEN-1:0]   r_skid_wdata;
  logic [LANES-1:0]        r_skid_wreg;

  logic                    w_accept;
  logic                    w_fire;
  logic                    w_drop;
  logic                    w_keep;
  logic [LANES-1:0]        w_wreg_masked;

  assign w_accept = in_valid & in_ready;
  assign w_fire   = out_valid & out_ready;
  assign w_drop   = w_accept & DedupEn & r_last_pc_valid & (in_pc == r_last_pc);
  assign w_keep   = w_accept & ~w_drop;

  // Writes to x0 are squashed once, at capture, so both slots hold final enables.
  always_comb begin
    w_wreg_masked = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_wreg_masked[i] = in_wreg[i] & (in_rd[i*REG_AW +: REG_AW] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StEmpty;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_rd          <= '0;
      out_wdata       <= '0;
      out_wreg        <= '0;
      retire_cnt      <= '0;
      r_last_pc       <= '0;
      r_last_pc_valid <= 1'b0;
      r_skid_pc       <= '0;
      r_skid_rd       <= '0;
      r_skid_wdata    <= '0;
      r_skid_wreg     <= '0;
    end else begin
      // A fire in a flush cycle still retires, so counting sits outside the flush branch.
      if (w_fire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end

      if (flush) begin
        r_state         <= StEmpty;
        in_ready        <= 1'b1;
        out_valid       <= 1'b0;
        out_pc          <= '0;
        out_rd          <= '0;
        out_wdata       <= '0;
        out_wreg        <= '0;
        r_last_pc_valid <= 1'b0;
      end else begin
        if (w_keep) begin
          r_last_pc       <= in_pc;
          r_last_pc_valid <= 1'b1;
        end

        unique case (r_state)
          StEmpty: begin
            in_ready <= 1'b1;
            if (w_keep) begin
              r_state   <= StOne;
              out_valid <= 1'b1;
              out_pc    <= in_pc;
              out_rd    <= in_rd;
              out_wdata <= in_wdata;
              out_wreg  <= w_wreg_masked;
            end
          end

          StOne: begin
            if (w_keep && w_fire) begin
              in_ready  <= 1'b1;
              out_pc    <= in_pc;
              out_rd    <= in_rd;
              out_wdata <= in_wdata;
              out_wreg  <= w_wreg_masked;
            end else if (w_keep) begin
              r_state      <= StFull;
              in_ready     <= 1'b0;
              r_skid_pc    <= in_pc;
              r_skid_rd    <= in_rd;
              r_skid_wdata <= in_wdata;
              r_skid_wreg  <= w_wreg_masked;
            end else if (w_fire) begin
              // Draining to empty leaves a zeroed NOP bubble on the outputs.
              r_state   <= StEmpty;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_pc    <= '0;
              out_rd    <= '0;
              out_wdata <= '0;
              out_wreg  <= '0;
            end else begin
              in_ready <= 1'b1;
            end
          end

          StFull: begin
            if (w_fire) begin
              r_state   <= StOne;
              in_ready  <= 1'b1;
              out_pc    <= r_skid_pc;
              out_rd    <= r_skid_rd;
              out_wdata <= r_skid_wdata;
              out_wreg  <= r_skid_wreg;
            end else begin
              in_ready <= 1'b0;
            end
          end

          default: begin
            r_state   <= StEmpty;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_wdata <= '0;
            out_wreg  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer: a 2-lane DEDUP=1 CNT_W=4 instance covers most
// behaviour; a 1-lane DEDUP=0 instance covers the non-deduplicating case.
module tb_wb_commit_buffer;

  logic clk;
  logic rst;

  // Instance A: LANES=2, DEDUP=1, CNT_W=4
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_pc, a_out_pc;
  logic [9:0]  a_in_rd, a_out_rd;
  logic [63:0] a_in_wdata, a_out_wdata;
  logic [1:0]  a_in_wreg, a_out_wreg;
  logic [3:0]  a_retire;

  // Instance B: LANES=1, DEDUP=0, CNT_W=32
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_pc, b_out_pc;
  logic [4:0]  b_in_rd, b_out_rd;
  logic [31:0] b_in_wdata, b_out_wdata;
  logic [0:0]  b_in_wreg, b_out_wreg;
  logic [31:0] b_retire;

  int n_checks = 0;
  int n_pass   = 0;
  int a_outs;
  int b_outs;

  wb_commit_buffer #(
    .XLEN(32), .REG_AW(5), .PC_W(32), .LANES(2), .DEDUP(1), .CNT_W(4)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .flush      (a_flush),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_pc      (a_in_pc),
    .in_rd      (a_in_rd),
    .in_wdata   (a_in_wdata),
    .in_wreg    (a_in_wreg),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_pc     (a_out_pc),
    .out_rd     (a_out_rd),
    .out_wdata  (a_out_wdata),
    .out_wreg   (a_out_wreg),
    .retire_cnt (a_retire)
  );

  wb_commit_buffer #(
    .XLEN(32), .REG_AW(5), .PC_W(32), .LANES(1), .DEDUP(0), .CNT_W(32)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .flush      (b_flush),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_pc      (b_in_pc),
    .in_rd      (b_in_rd),
    .in_wdata   (b_in_wdata),
    .in_wreg    (b_in_wreg),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_pc     (b_out_pc),
    .out_rd     (b_out_rd),
    .out_wdata  (b_out_wdata),
    .out_wreg   (b_out_wreg),
    .retire_cnt (b_retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_offer(input logic [31:0] pc, input logic [9:0] rd,
                         input logic [63:0] wd, input logic [1:0] we);
    a_in_valid = 1'b1;
    a_in_pc    = pc;
    a_in_rd    = rd;
    a_in_wdata = wd;
    a_in_wreg  = we;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    a_in_pc = 0; a_in_rd = 0; a_in_wdata = 0; a_in_wreg = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    b_in_pc = 0; b_in_rd = 0; b_in_wdata = 0; b_in_wreg = 0;
    #1;
    step();
    step();
    check("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_out_wreg", {62'd0, a_out_wreg}, 64'd0);
    check("rst_retire", {60'd0, a_retire}, 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", {63'd0, a_in_ready}, 64'd1);

    // 1: single entry
    a_out_ready = 1'b1;
    a_offer(32'h100, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 2'b01);
    step();
    a_in_valid = 1'b0;
    check("t1_out_valid", {63'd0, a_out_valid}, 64'd1);
    check("t1_out_pc", {32'd0, a_out_pc}, 64'h100);
    check("t1_out_rd", {54'd0, a_out_rd}, 64'd5);
    check("t1_out_wdata", a_out_wdata, 64'hDEADBEEF);
    check("t1_out_wreg", {62'd0, a_out_wreg}, 64'd1);
    step();
    check("t1_retire", {60'd0, a_retire}, 64'd1);
    check("t1_bubble_valid", {63'd0, a_out_valid}, 64'd0);
    check("t1_bubble_pc", {32'd0, a_out_pc}, 64'd0);

    // 2: backpressure fills the skid slot
    a_out_ready = 1'b0;
    a_offer(32'h104, 10'd1, 64'd1, 2'b01);
    step();
    a_offer(32'h108, 10'd2, 64'd2, 2'b01);
    step();
    a_in_valid = 1'b0;
    check("t2_full_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("t2_hold_pc", {32'd0, a_out_pc}, 64'h104);
    step();
    check("t2_stable_pc", {32'd0, a_out_pc}, 64'h104);
    check("t2_stable_valid", {63'd0, a_out_valid}, 64'd1);
    a_out_ready = 1'b1;
    step();
    check("t2_second_pc", {32'd0, a_out_pc}, 64'h108);
    check("t2_second_rd", {54'd0, a_out_rd}, 64'd2);
    check("t2_ready_back", {63'd0, a_in_ready}, 64'd1);
    step();
    check("t2_drained", {63'd0, a_out_valid}, 64'd0);
    check("t2_retire", {60'd0, a_retire}, 64'd3);

    // 3: same pc offered three times; A drops repeats, B keeps all
    a_outs = 0;
    b_outs = 0;
    b_out_ready = 1'b1;
    a_offer(32'h200, 10'd3, 64'd9, 2'b01);
    b_in_valid = 1'b1; b_in_pc = 32'h200; b_in_rd = 5'd3; b_in_wdata = 32'd9; b_in_wreg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_out_valid) a_outs++;
      if (b_out_valid) b_outs++;
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    step();
    check("t3_dedup_outs", 64'(a_outs), 64'd1);
    check("t3_dedup_retire", {60'd0, a_retire}, 64'd4);
    check("t3_nodedup_outs", 64'(b_outs), 64'd3);
    check("t3_nodedup_retire", {32'd0, b_retire}, 64'd3);

    // 4: x0 masking
    a_out_ready = 1'b0;
    a_offer(32'h300, {5'd0, 5'd0}, {32'h0, 32'h55}, 2'b01);
    step();
    check("t4_valid", {63'd0, a_out_valid}, 64'd1);
    check("t4_x0_wreg", {62'd0, a_out_wreg}, 64'd0);
    check("t4_wdata", a_out_wdata, 64'h55);
    a_out_ready = 1'b1;
    a_offer(32'h304, {5'd7, 5'd0}, {32'h77, 32'h66}, 2'b11);
    step();
    a_in_valid = 1'b0;
    check("t4_lane_pc", {32'd0, a_out_pc}, 64'h304);
    check("t4_lane_wreg", {62'd0, a_out_wreg}, 64'd2);
    step();
    check("t4_retire", {60'd0, a_retire}, 64'd6);

    // 5: flush while full with a concurrent offer
    a_out_ready = 1'b0;
    a_offer(32'h400, 10'd4, 64'd4, 2'b01);
    step();
    a_offer(32'h404, 10'd5, 64'd5, 2'b01);
    step();
    check("t5_full", {63'd0, a_in_ready}, 64'd0);
    a_flush = 1'b1;
    a_offer(32'h408, 10'd6, 64'd6, 2'b01);
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    check("t5_valid", {63'd0, a_out_valid}, 64'd0);
    check("t5_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("t5_pc", {32'd0, a_out_pc}, 64'd0);
    check("t5_rd", {54'd0, a_out_rd}, 64'd0);
    check("t5_wdata", a_out_wdata, 64'd0);
    check("t5_wreg", {62'd0, a_out_wreg}, 64'd0);
    check("t5_retire", {60'd0, a_retire}, 64'd6);
    a_offer(32'h404, 10'd5, 64'd5, 2'b01);
    step();
    a_in_valid = 1'b0;
    check("t5_reoffer_valid", {63'd0, a_out_valid}, 64'd1);
    check("t5_reoffer_pc", {32'd0, a_out_pc}, 64'h404);
    // A fire coinciding with flush still retires.
    a_out_ready = 1'b1;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    check("t5_flush_fire_retire", {60'd0, a_retire}, 64'd7);
    check("t5_flush_fire_valid", {63'd0, a_out_valid}, 64'd0);

    // 6: reset while full, then counter wrap
    a_out_ready = 1'b0;
    a_offer(32'h500, 10'd1, 64'd1, 2'b01);
    step();
    a_offer(32'h504, 10'd2, 64'd2, 2'b01);
    step();
    a_in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("t6_rst_valid", {63'd0, a_out_valid}, 64'd0);
    check("t6_rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("t6_rst_pc", {32'd0, a_out_pc}, 64'd0);
    check("t6_rst_retire", {60'd0, a_retire}, 64'd0);
    rst = 1'b0;
    step();
    check("t6_release_in_ready", {63'd0, a_in_ready}, 64'd1);
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_offer(32'h600 + 32'(i * 4), 10'd1, 64'(i), 2'b01);
      step();
    end
    a_in_valid = 1'b0;
    check("t6_retire_15", {60'd0, a_retire}, 64'd15);
    step();
    check("t6_wrap", {60'd0, a_retire}, 64'd0);
    check("t6_wrap_valid", {63'd0, a_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
